instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, meaning reset, asynchronous and active-high.
REQ-004 The block SHALL have port mem_req_valid, output, 1, meaning a fetch request is presented.
REQ-005 The block SHALL have port mem_req_ready, input, 1, meaning memory accepts the request.
REQ-006 The block SHALL have port mem_addr, output, 32, meaning the fetch byte address, equal to pc.
REQ-007 The block SHALL have port mem_rsp_valid, input, 1, meaning the fetch data is valid this cycle.
REQ-008 The block SHALL have port mem_rsp_data, input, 32, meaning the instruction word.
REQ-009 The block SHALL have port redirect_valid, input, 1, meaning a one-cycle control-flow change.
REQ-010 The block SHALL have port redirect_pc, input, 32, meaning the new fetch address.
REQ-011 The block SHALL have port output_valid, output, 1, meaning output_pc and output_instr are valid.
REQ-012 The block SHALL have port output_ready, input, 1, meaning downstream accepts.
REQ-013 The block SHALL have port output_pc, output, 32, meaning the address of output_instr.
REQ-014 The block SHALL have port output_instr, output, 32, meaning the fetched instruction.

Function
REQ-015 The block SHALL keep at most one memory request outstanding.
REQ-016 The block SHALL implement the states REQUEST, WAIT and HOLD.
REQ-017 In REQUEST, mem_req_valid SHALL be 1 and mem_addr SHALL equal pc; on mem_req_ready the block SHALL go to WAIT next cycle.
REQ-018 In WAIT, on mem_rsp_valid the block SHALL register output_pc=pc and output_instr=mem_rsp_data, set output_valid=1, set pc=pc+4, and go to HOLD.
REQ-019 The response-to-output_valid latency SHALL be exactly 1 cycle.
REQ-020 In HOLD, output_valid=1 and output_pc/output_instr SHALL stay stable until output_valid&&output_ready.
REQ-021 On that HOLD handshake, output_valid SHALL be 0 next cycle and the state SHALL return to REQUEST.
REQ-022 The pc+4 increment SHALL wrap modulo 2^32, so 32'hFFFF_FFFC is followed by 32'h0000_0000.
REQ-023 redirect_valid SHALL load pc with {redirect_pc[31:2],2'b00}, overriding any increment in the same cycle.
REQ-024 Redirect in REQUEST without mem_req_ready: the block SHALL stay in REQUEST with the new pc.
REQ-025 Redirect in REQUEST with mem_req_ready: the block SHALL go to WAIT and set discard=1.
REQ-026 Redirect in WAIT: the block SHALL set discard=1; a response arriving in the same cycle SHALL be dropped and the block SHALL go to REQUEST.
REQ-027 In WAIT with discard=1, the next response SHALL be dropped with no output_valid; discard SHALL clear and the block SHALL go to REQUEST.
REQ-028 Redirect in HOLD: the held output SHALL be squashed, with output_valid=0 next cycle regardless of output_ready, and the block SHALL go to REQUEST.
REQ-029 A response received outside WAIT SHALL be ignored.

Reset
REQ-030 While reset is asserted, the block SHALL hold output_valid=0, mem_req_valid=0, pc=RESET_PC, state=REQUEST and discard=0.
REQ-031 output_pc and output_instr SHALL reset to 0.
REQ-032 The first request SHALL be presented in the first cycle after reset deasserts.
REQ-033 Reset asserted mid-transaction SHALL abandon it, and a late response SHALL be ignored per REQ-029.

Structure
REQ-034 The FSM state enum, the value 4 used as INSTR_BYTES, and the RESET_PC default SHALL live in the shared cpu_pkg package.
REQ-035 No sub-module is needed; the pc incrementer and FSM SHALL be inline, and output decoupling SHALL be left to the downstream stage.

Verification
REQ-036 Reset release with RESET_PC=0 and a response 32'h0000_0013 one cycle after request accept -> output_valid with output_pc=0 and output_instr=32'h13, then the next request at mem_addr=4.
REQ-037 output_ready held 0 for 5 cycles in HOLD -> output_valid stays 1 with output_pc and output_instr unchanged, and mem_req_valid stays 0.
REQ-038 Redirect to 32'h100 in the same cycle as the response in WAIT -> no output_valid, and the next request is at mem_addr=32'h100.
REQ-039 Redirect to 32'h203 in the same cycle as a request accept at pc=8 -> that response is dropped, and the next request is at 32'h200.
REQ-040 pc=32'hFFFF_FFFC with a completed fetch -> the next mem_addr is 32'h0000_0000.
REQ-041 Reset asserted in WAIT with a response arriving one cycle after release -> no output_valid from that response, and mem_req_valid=1 at mem_addr=RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM states, instruction size,
// default reset vector and small pc helpers.
package cpu_pkg;

    typedef enum logic [1:0] {
        REQUEST = 2'd0,
        WAIT    = 2'd1,
        HOLD    = 2'd2
    } fetch_state_t;

    localparam logic [31:0] INSTR_BYTES      = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Sequential successor; 32-bit arithmetic wraps naturally at 2^32.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + INSTR_BYTES;
    endfunction

    // Redirect targets are forced onto a word boundary.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch unit: requests one word at pc,
// waits for its response, holds it until the decode stage accepts it.
// Redirects reload pc; a response belonging to a stale request is dropped.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        output_valid,
    input  logic        output_ready,
    output logic [31:0] output_pc,
    output logic [31:0] output_instr
);

    fetch_state_t state_reg;
    logic [31:0]  pc_reg;
    logic         discard_reg;
    logic         mem_req_valid_reg;
    logic         output_valid_reg;
    logic [31:0]  output_pc_reg;
    logic [31:0]  output_instr_reg;

    assign mem_req_valid = mem_req_valid_reg;
    assign mem_addr      = pc_reg;
    assign output_valid  = output_valid_reg;
    assign output_pc     = output_pc_reg;
    assign output_instr  = output_instr_reg;

    // Fetch FSM: pc sequencing, request issue, response capture and output hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg         <= REQUEST;
            pc_reg            <= RESET_PC;
            discard_reg       <= 1'b0;
            mem_req_valid_reg <= 1'b0;
            output_valid_reg  <= 1'b0;
            output_pc_reg     <= 32'h0000_0000;
            output_instr_reg  <= 32'h0000_0000;
        end else begin
            case (state_reg)
                REQUEST: begin
                    if (redirect_valid) begin
                        pc_reg <= align_pc(redirect_pc);
                    end
                    if (mem_req_valid_reg && mem_req_ready) begin
                        // The accepted request used the old pc; if a redirect
                        // lands now, its response must be thrown away.
                        state_reg         <= WAIT;
                        mem_req_valid_reg <= 1'b0;
                        discard_reg       <= redirect_valid;
                    end else begin
                        mem_req_valid_reg <= 1'b1;
                    end
                end

                WAIT: begin
                    if (redirect_valid) begin
                        pc_reg <= align_pc(redirect_pc);
                        if (mem_rsp_valid) begin
                            // Response consumed and dropped in the same cycle.
                            state_reg         <= REQUEST;
                            mem_req_valid_reg <= 1'b1;
                            discard_reg       <= 1'b0;
                        end else begin
                            discard_reg <= 1'b1;
                        end
                    end else if (mem_rsp_valid) begin
                        if (discard_reg) begin
                            discard_reg       <= 1'b0;
                            state_reg         <= REQUEST;
                            mem_req_valid_reg <= 1'b1;
                        end else begin
                            output_pc_reg    <= pc_reg;
                            output_instr_reg <= mem_rsp_data;
                            output_valid_reg <= 1'b1;
                            pc_reg           <= next_pc(pc_reg);
                            state_reg        <= HOLD;
                        end
                    end
                end

                HOLD: begin
                    if (redirect_valid) begin
                        // Squash the held instruction regardless of output_ready.
                        pc_reg            <= align_pc(redirect_pc);
                        output_valid_reg  <= 1'b0;
                        state_reg         <= REQUEST;
                        mem_req_valid_reg <= 1'b1;
                    end else if (output_ready) begin
                        output_valid_reg  <= 1'b0;
                        state_reg         <= REQUEST;
                        mem_req_valid_reg <= 1'b1;
                    end
                end

                default: begin
                    state_reg         <= REQUEST;
                    mem_req_valid_reg <= 1'b1;
                    output_valid_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch: a memory model answers accepted
// requests after a random delay, redirects are injected at random, and a
// scoreboard checks every delivered instruction against the architectural
// fetch stream (sequential pc, reloaded by redirects).
module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        output_valid;
    logic        output_ready = 1'b0;
    logic [31:0] output_pc;
    logic [31:0] output_instr;

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];
    logic [31:0] exp_pc;

    // memory model state
    bit          pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          pend_cnt = 0;
    bit          live = 1'b0;
    bit          expect_ov = 1'b0;

    // values sampled at the negedge preceding each active edge
    bit          s_rdr, s_hs, s_acc, s_rsp, s_live;
    logic [31:0] s_rpc, s_addr;

    // monitor history
    bit          prev_ov = 1'b0, prev_hs = 1'b0, prev_rdr = 1'b0;
    logic [31:0] prev_pc = 32'h0, prev_instr = 32'h0;

    instruction_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .output_valid  (output_valid),
        .output_ready  (output_ready),
        .output_pc     (output_pc),
        .output_instr  (output_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0100;
            1:       return 32'h0000_0203;
            2:       return 32'hFFFF_FFF0;
            3:       return 32'hFFFF_FFFC;
            4:       return 32'hFFFF_FFF9;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic restart_stream(input logic [31:0] pc);
        exp_pc = pc;
        exp_q.delete();
        exp_q.push_back('{pc, mem_word(pc)});
    endtask

    // Monitor: pops the scoreboard on every accepted output and checks
    // protocol rules (hold stability, single outstanding request).
    always @(negedge clk) begin
        if (reset) begin
            chk("reset_output_valid", {31'b0, output_valid}, 32'h0);
            chk("reset_mem_req_valid", {31'b0, mem_req_valid}, 32'h0);
            chk("reset_output_pc", output_pc, 32'h0);
            chk("reset_output_instr", output_instr, 32'h0);
            prev_ov = 1'b0;
            prev_hs = 1'b0;
            prev_rdr = 1'b0;
        end else begin
            chk("one_outstanding", {31'b0, output_valid & mem_req_valid}, 32'h0);
            if (prev_ov) begin
                if (prev_hs || prev_rdr) begin
                    chk("valid_clear_after_accept_or_squash", {31'b0, output_valid}, 32'h0);
                end else begin
                    chk("hold_valid", {31'b0, output_valid}, 32'h1);
                    chk("hold_pc_stable", output_pc, prev_pc);
                    chk("hold_instr_stable", output_instr, prev_instr);
                end
            end
            if (output_valid && output_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_nonempty", 32'h0, 32'h1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("output_pc", output_pc, e.pc);
                    chk("output_instr", output_instr, e.instr);
                    $display("out  pc=%h instr=%h", output_pc, output_instr);
                end
            end
            if (mem_req_valid && mem_req_ready && !redirect_valid) begin
                if (exp_q.size() == 0) chk("scoreboard_nonempty_req", 32'h0, 32'h1);
                else chk("request_addr", mem_addr, exp_q[0].pc);
            end
            prev_ov    = output_valid;
            prev_hs    = output_valid && output_ready;
            prev_rdr   = redirect_valid;
            prev_pc    = output_pc;
            prev_instr = output_instr;
        end
    end

    // One clock of stimulus: sample at negedge, advance model after the edge,
    // then drive the next cycle's inputs.
    task automatic step(input bit allow_rdr, input int rdy_pct, input int req_pct, input bit quick);
        @(negedge clk);
        s_rdr  = redirect_valid;
        s_rpc  = redirect_pc;
        s_hs   = output_valid && output_ready;
        s_acc  = mem_req_valid && mem_req_ready;
        s_addr = mem_addr;
        s_rsp  = mem_rsp_valid;
        s_live = s_acc && !s_rdr && (exp_q.size() > 0) && (mem_addr == exp_q[0].pc);
        if (expect_ov) begin
            chk("rsp_to_valid_latency", {31'b0, output_valid}, 32'h1);
            expect_ov = 1'b0;
        end
        if (s_rsp && live && !s_rdr) expect_ov = 1'b1;

        @(posedge clk);
        #1;
        if (s_rdr) restart_stream({s_rpc[31:2], 2'b00});
        else if (s_hs) begin
            exp_pc = exp_pc + 32'd4;
            exp_q.push_back('{exp_pc, mem_word(exp_pc)});
        end

        if (s_rsp) begin
            pend = 1'b0;
            live = 1'b0;
        end
        if (s_acc) begin
            pend      = 1'b1;
            pend_addr = s_addr;
            pend_cnt  = quick ? 0 : $urandom_range(0, 2);
            live      = s_live;
        end
        if (s_rdr) live = 1'b0;

        if (pend && pend_cnt == 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_word(pend_addr);
        end else if (pend) begin
            mem_rsp_valid = 1'b0;
            pend_cnt--;
        end else begin
            mem_rsp_valid = ($urandom_range(0, 7) == 0);
            mem_rsp_data  = $urandom;
        end
        mem_req_ready  = !pend && ($urandom_range(0, 99) < req_pct);
        output_ready   = ($urandom_range(0, 99) < rdy_pct);
        redirect_valid = allow_rdr && ($urandom_range(0, 99) < 8);
        redirect_pc    = pick_target();
    endtask

    // Reset while a request is outstanding; its response arrives after release.
    task automatic reset_mid();
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        while (!got && n < 100) begin
            step(1'b0, 100, 100, 1'b0);
            n++;
            if (pend && !mem_rsp_valid) got = 1'b1;
        end
        chk("reset_mid_wait_reached", {31'b0, got}, 32'h1);
        reset          = 1'b1;
        mem_rsp_valid  = 1'b0;
        mem_req_ready  = 1'b0;
        redirect_valid = 1'b0;
        output_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        restart_stream(RESET_PC);
        live      = 1'b0;
        expect_ov = 1'b0;
        if (pend) begin
            pend_cnt      = 0;
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_word(pend_addr);
        end
        step(1'b0, 100, 100, 1'b1);
        chk("post_reset_req_valid", {31'b0, mem_req_valid}, 32'h1);
        chk("post_reset_req_addr", mem_addr, RESET_PC);
        chk("late_rsp_no_output", {31'b0, output_valid}, 32'h0);
    endtask

    initial begin
        restart_stream(RESET_PC);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b0, 100, 100, 1'b1);
        chk("first_req_valid", {31'b0, mem_req_valid}, 32'h1);
        chk("first_req_addr", mem_addr, RESET_PC);

        repeat (20) step(1'b0, 100, 100, 1'b1);
        repeat (12) step(1'b0, 0, 100, 1'b1);
        repeat (5) step(1'b0, 100, 100, 1'b1);
        repeat (3000) step(1'b1, 60, 60, 1'b0);
        reset_mid();
        repeat (500) step(1'b1, 60, 60, 1'b0);
        reset_mid();
        repeat (200) step(1'b1, 70, 70, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
